// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small transmit FIFO in front of the serializer.
// tx_out and tx_done are registered; tx_ready/tx_busy decode registered state.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [13:0] BIT_LAST = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] DONE_AT  = 14'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       shift;
  logic [13:0]      bit_cnt;
  logic [2:0]       bit_idx;
  logic             push;
  logic             pop;

  assign tx_ready = (count < CNT_W'(FIFO_DEPTH));
  assign tx_busy  = (state != IDLE) || (count != '0);
  // A write coinciding with reset must not land in the buffer.
  assign push     = tx_valid && tx_ready && !reset;
  assign pop      = (state == IDLE) && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_out  <= 1'b1;
      tx_done <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            bit_idx <= '0;
            tx_out  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            tx_out  <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_out  <= shift[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          // Raised one edge early so the registered pulse lands on the last stop cycle.
          if (bit_cnt == DONE_AT) begin
            tx_done <= 1'b1;
          end
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          tx_out <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
